// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon button-capture path and the game FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LISTEN  = 2'd1,
    LOCKOUT = 2'd2
  } cap_state_e;

  // 20 ms at 50 MHz
  localparam int LOCKOUT_CYCLES_DEF = 1_000_000;
  // 5 s at 50 MHz
  localparam int TIMEOUT_CYCLES_DEF = 250_000_000;

  // Width of a button index; never narrower than one bit.
  function automatic int btn_idx_w(input int num_buttons);
    return (num_buttons < 2) ? 1 : $clog2(num_buttons);
  endfunction

endpackage

// File: rtl/simon_evt_fifo.sv
// Small synchronous event FIFO with a registered first-word-fall-through head.
// Latency: a push into an empty FIFO shows at the head on the next cycle.
// Backpressure: push while full is accepted only if a pop happens the same cycle.
module simon_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [AW-1:0]    rd_nxt_idx;
  logic             do_push;
  logic             do_pop;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign full       = (count == PW'(DEPTH));
  assign rd_nxt_idx = rd_ptr[AW-1:0] + AW'(1);
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);

  // Storage, pointers and the head register; the head only changes when a new
  // entry becomes visible, so it holds its last value while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_dat <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (empty && do_push)            head_dat <= push_dat;
      else if (do_pop && count > PW'(1)) head_dat <= mem[rd_nxt_idx];
      else if (do_pop && do_push)      head_dat <= push_dat;
    end
  end

endmodule

// File: rtl/simon_input_capture.sv
// Turns button press pulses into debounced, priority-encoded events buffered for the game FSM.
// Latency: accepted press in cycle n -> evt_valid/evt_btn in cycle n+1; busy for LOCKOUT_CYCLES.
// Backpressure: evt_valid/evt_ready; a press with the FIFO full and no pop is dropped and flagged.
// Optional idle-timeout pulse enabled by defining INPUT_TIMEOUT_EN.
module simon_input_capture
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_BUTTONS-1:0]              press_pulse,
  input  logic                                arm,
  output logic                                evt_valid,
  input  logic                                evt_ready,
  output logic [btn_idx_w(NUM_BUTTONS)-1:0]   evt_btn,
  output logic                                evt_overflow,
  input  logic                                overflow_clr,
  output logic                                busy,
  output logic                                timeout
);

  localparam int BW  = btn_idx_w(NUM_BUTTONS);
  localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);

  typedef logic [BW-1:0] btn_idx_t;

  cap_state_e     state;
  logic [LCW-1:0] lock_cnt;
  btn_idx_t       enc_btn;
  logic           any_press;
  logic           accept;
  logic           pop_fire;
  logic           fifo_empty;
  logic           fifo_full;

  // Lowest-index pressed button wins; scan from the top so the lowest set bit is last written.
  always_comb begin
    enc_btn = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (press_pulse[i]) enc_btn = btn_idx_t'(i);
    end
  end

  assign any_press = |press_pulse;
  assign accept    = (state == LISTEN) && arm && any_press;
  assign evt_valid = ~fifo_empty;
  assign pop_fire  = evt_valid & evt_ready;

  simon_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (enc_btn),
    .pop      (evt_ready),
    .flush    (~arm),
    .head_dat (evt_btn),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Capture FSM with lockout counter; disarming returns to IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
      busy     <= 1'b0;
    end else if (!arm) begin
      state    <= IDLE;
      lock_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= LISTEN;
        LISTEN: begin
          if (any_press) begin
            state    <= LOCKOUT;
            lock_cnt <= LCW'(LOCKOUT_CYCLES - 1);
            busy     <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= LISTEN;
            busy  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt - LCW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  evt_overflow <= 1'b0;
    else if (accept && fifo_full && !pop_fire)   evt_overflow <= 1'b1;
    else if (overflow_clr)                       evt_overflow <= 1'b0;
  end

`ifdef INPUT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] to_cnt;

  // Idle timer: counts only while listening with nothing queued, pulses and restarts at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!arm || state != LISTEN || accept) begin
        to_cnt <= '0;
      end else if (fifo_empty) begin
        if (to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt  <= '0;
          timeout <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TCW'(1);
        end
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_simon_input_capture.sv
// Directed bench for simon_input_capture with an event scoreboard.
// Latency: n/a.
// Backpressure: the bench drives evt_ready explicitly per scenario.
module tb_simon_input_capture;

  localparam int NB   = 4;
  localparam int LOCK = 8;
  localparam int DEP  = 4;
  localparam int TOC  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] press_pulse;
  logic          arm;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_btn;
  logic          evt_overflow;
  logic          overflow_clr;
  logic          busy;
  logic          timeout;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  simon_input_capture #(
    .NUM_BUTTONS    (NB),
    .LOCKOUT_CYCLES (LOCK),
    .FIFO_DEPTH     (DEP),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .press_pulse  (press_pulse),
    .arm          (arm),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_btn      (evt_btn),
    .evt_overflow (evt_overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One-cycle press; optionally records the expected encoded button.
  task automatic press(input logic [NB-1:0] bits, input bit queued, input int btn);
    press_pulse = bits;
    if (queued) exp_q.push_back(btn);
    tick();
    press_pulse = '0;
  endtask

  // Scoreboard monitor: compares the head whenever a handshake will occur at the next edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && evt_valid && evt_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL evt_unexpected: got btn %0d expected no event", evt_btn);
        end else begin
          e = exp_q.pop_front();
          if (int'(evt_btn) != e) begin
            n_err++;
            $display("FAIL evt_btn: got %0d expected %0d", evt_btn, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    arm          = 1'b0;
    press_pulse  = '0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (2) tick();
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_btn", evt_btn, 0);
    check("rst_overflow", evt_overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);

    // Single press, latency and lockout window
    rst_n = 1'b1;
    arm   = 1'b1;
    tick();
    press(4'b0100, 1'b1, 2);
    check("lat_evt_valid", evt_valid, 1);
    check("lat_evt_btn", evt_btn, 2);
    for (int i = 0; i < LOCK; i++) begin
      check("busy_window", busy, 1);
      tick();
    end
    check("busy_end", busy, 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("drain_empty", evt_valid, 0);

    // Simultaneous bits and a press during lockout
    press(4'b1010, 1'b1, 1);
    check("prio_evt_btn", evt_btn, 1);
    tick();
    press(4'b0001, 1'b0, 0);
    check("lockout_busy", busy, 1);
    repeat (LOCK) tick();
    evt_ready = 1'b1;
    repeat (3) tick();
    evt_ready = 1'b0;
    check("lockout_no_evt", evt_valid, 0);

    // Fill, overflow, clear, set-over-clear, full with pop and push together
    press(4'b1001, 1'b1, 0); repeat (9) tick();
    press(4'b1000, 1'b1, 3); repeat (9) tick();
    press(4'b0110, 1'b1, 1); repeat (9) tick();
    press(4'b1100, 1'b1, 2); repeat (9) tick();
    check("ovf_before", evt_overflow, 0);
    press(4'b1000, 1'b0, 0);
    check("ovf_set", evt_overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_head", evt_btn, 0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", evt_overflow, 0);
    repeat (8) tick();
    overflow_clr = 1'b1;
    press(4'b0001, 1'b0, 0);
    overflow_clr = 1'b0;
    check("ovf_set_wins", evt_overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr2", evt_overflow, 0);
    repeat (9) tick();
    evt_ready = 1'b1;
    press(4'b0100, 1'b1, 2);
    evt_ready = 1'b0;
    check("full_pop_push_ovf", evt_overflow, 0);
    check("full_pop_push_vld", evt_valid, 1);

    // Disarm flushes the queue and ignores presses
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (9) tick();
    check("pre_flush_valid", evt_valid, 1);
    arm = 1'b0;
    tick();
    exp_q.delete();
    check("flush_valid", evt_valid, 0);
    press(4'b0010, 1'b0, 0);
    check("disarm_no_evt", evt_valid, 0);
    check("disarm_busy", busy, 0);

    // Reset in the middle of lockout with two events queued
    arm = 1'b1;
    tick();
    press(4'b0001, 1'b1, 0); repeat (9) tick();
    press(4'b1000, 1'b1, 3);
    repeat (2) tick();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", evt_valid, 1);
    rst_n = 1'b0;
    arm   = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_valid", evt_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", evt_overflow, 0);
    check("midrst_btn", evt_btn, 0);
    rst_n = 1'b1;
    tick();

    // Idle timeout from LISTEN entry
    arm = 1'b1;
    tick();
    for (int k = 1; k <= 45; k++) begin
      int exp_to;
      tick();
`ifdef INPUT_TIMEOUT_EN
      exp_to = (k == 20 || k == 40) ? 1 : 0;
`else
      exp_to = 0;
`endif
      check("timeout", timeout, exp_to);
    end

    check("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
